// File: rtl/spi_servo_rx_pkg.sv
// Shared constants and types for the servo SPI link (receiver and master-side transmitter).
package spi_servo_pkg;

  localparam int FRAME_BITS  = 16;
  localparam int ADDR_BITS   = 4;
  localparam int DATA_BITS   = FRAME_BITS - ADDR_BITS;
  localparam int TIMEOUT_CYC = 3000;
  // Cycles DRAIN waits after entry so the synchronisers reflect the real cs_n level.
  localparam int SETTLE_CYC  = 3;

  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam int TMO_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2
  } rx_state_t;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] data;
  } frame_t;

  function automatic frame_t to_frame(input logic [FRAME_BITS-1:0] bits);
    return frame_t'(bits);
  endfunction

endpackage

// File: rtl/spi_servo_rx_if.sv
// SPI pins plus received-frame outputs of the servo receiver.
interface spi_servo_rx_if;
  import spi_servo_pkg::*;

  logic                 spi_sclk;
  logic                 spi_cs_n;
  logic                 spi_mosi;
  logic [ADDR_BITS-1:0] rx_addr;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_err;
  logic                 busy;

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi,
    input  rx_addr, rx_data, rx_valid, rx_err, busy
  );

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi,
    output rx_addr, rx_data, rx_valid, rx_err, busy
  );

endinterface

// File: rtl/spi_servo_rx_sync_edge_det.sv
// Two-flop synchroniser with history flop; level and edge pulses are mutually aligned.
module sync_edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q, sync_d;
  logic       hist_q, hist_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[0], async_i};
    hist_d = sync_q[1];
    rise_d = sync_q[1] & ~hist_q;
    fall_d = ~sync_q[1] & hist_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{RST_VAL}};
      hist_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // hist_q is the level that produced the registered edge, so data sampled on rise_o lines up.
  assign level_o = hist_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/spi_servo_rx.sv
// SPI mode-0 slave receiving fixed-length servo frames (channel address + position word).
module spi_servo_rx
  import spi_servo_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  spi_servo_rx_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0] SETTLE   = TMO_W'(SETTLE_CYC);

  logic sclk_rise, sclk_level_unused, sclk_fall_unused;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  sync_edge_det #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (bus.spi_sclk),
    .level_o (sclk_level_unused),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall_unused)
  );

  sync_edge_det #(.RST_VAL(1'b1)) u_sync_cs (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (bus.spi_cs_n),
    .level_o (cs_level),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  sync_edge_det #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (bus.spi_mosi),
    .level_o (mosi_level),
    .rise_o  (mosi_rise_unused),
    .fall_o  (mosi_fall_unused)
  );

  rx_state_t             state_q, state_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic [TMO_W-1:0]      tmo_q,   tmo_d;
  frame_t                frame_q, frame_d;
  logic                  valid_q, valid_d;
  logic                  err_q,   err_d;
  logic                  busy_q,  busy_d;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    frame_d = frame_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
          tmo_d   = '0;
        end
      end
      SHIFT: begin
        // Priority: CS rise, then SCLK rise, then timeout.
        if (cs_rise) begin
          if (cnt_q == CNT_FULL) begin
            frame_d = to_frame(shreg_q);
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end else if (sclk_rise) begin
          shreg_d = {shreg_q[FRAME_BITS-2:0], mosi_level};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
          tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = DRAIN;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DRAIN: begin
        // Settling keeps a frame caught mid-flight after reset from looking like a fresh CS fall.
        if (tmo_q < SETTLE) begin
          tmo_d = tmo_q + 1'b1;
        end else if (cs_level) begin
          state_d = IDLE;
        end
      end
      default: state_d = DRAIN;
    endcase
    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DRAIN;
      shreg_q <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.rx_addr  = frame_q.addr;
  assign bus.rx_data  = frame_q.data;
  assign bus.rx_valid = valid_q;
  assign bus.rx_err   = err_q;
  assign bus.busy     = busy_q;

endmodule
